// File: rtl/rs_scheduler_pkg.sv
// Shared widths, CDB/entry payload types and tag-wakeup helpers for the reservation station.
package rs_scheduler_pkg;

    localparam int unsigned RS_SIZE = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = IDX_W + 1;

    localparam logic [TAG_W-1:0] TAG_READY = '0;

    typedef struct packed {
        logic              ok;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } cdb_t;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  qi;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vi;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [TAG_W-1:0]  rob_id;
    } rs_entry_t;

    // Tag 0 means "value already present", so it can never be woken.
    function automatic logic tag_hit(input cdb_t c, input logic [TAG_W-1:0] q);
        return c.ok && (q != TAG_READY) && (q == c.tag);
    endfunction

    function automatic rs_entry_t wake(input rs_entry_t e, input cdb_t a, input cdb_t l);
        rs_entry_t r;
        r = e;
        if (tag_hit(a, e.qi)) begin
            r.qi = TAG_READY;
            r.vi = a.val;
        end else if (tag_hit(l, e.qi)) begin
            r.qi = TAG_READY;
            r.vi = l.val;
        end
        if (tag_hit(a, e.qj)) begin
            r.qj = TAG_READY;
            r.vj = a.val;
        end else if (tag_hit(l, e.qj)) begin
            r.qj = TAG_READY;
            r.vj = l.val;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder; used both for ready-entry select and free-slot search.
module rs_select #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx_c,
    output logic         o_found_c
);

    always_comb begin
        o_idx_c   = '0;
        o_found_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx_c   = W'(i);
                o_found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_scheduler.sv
// ALU reservation station: inserts from Issue, wakes entries from the ALU/LSB CDBs, dispatches
// one ready entry per cycle. Optional macro RS_WAKEUP_BYPASS_EN selects entries woken this cycle.
module rs_scheduler
    import rs_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              ena_rs,
    input  logic [OP_W-1:0]   op_in,
    input  logic [TAG_W-1:0]  Qi_in,
    input  logic [TAG_W-1:0]  Qj_in,
    input  logic [DATA_W-1:0] Vi_in,
    input  logic [DATA_W-1:0] Vj_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [TAG_W-1:0]  rob_id_in,
    output logic              rs_full,
    input  logic              cdb_alu_ok,
    input  logic [TAG_W-1:0]  cdb_alu_tag,
    input  logic [DATA_W-1:0] cdb_alu_val,
    input  logic              cdb_lsb_ok,
    input  logic [TAG_W-1:0]  cdb_lsb_tag,
    input  logic [DATA_W-1:0] cdb_lsb_val,
    output logic              alu_ena,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_vi,
    output logic [DATA_W-1:0] alu_vj,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic [TAG_W-1:0]  alu_rob_id
);

    rs_entry_t          r_ent     [RS_SIZE];
    rs_entry_t          w_woken   [RS_SIZE];
    rs_entry_t          w_ent_nxt [RS_SIZE];
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [RS_SIZE-1:0] w_ready;
    logic [RS_SIZE-1:0] w_free;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_sel_found;
    logic               w_free_found;
    logic               w_ins;
    logic               w_disp;
    cdb_t               w_cdb_alu;
    cdb_t               w_cdb_lsb;
    rs_entry_t          w_in_raw;
    rs_entry_t          w_new;
    rs_entry_t          w_win;

    assign w_cdb_alu = {cdb_alu_ok, cdb_alu_tag, cdb_alu_val};
    assign w_cdb_lsb = {cdb_lsb_ok, cdb_lsb_tag, cdb_lsb_val};
    assign w_in_raw  = {1'b1, op_in, Qi_in, Qj_in, Vi_in, Vj_in, imm_in, pc_in, rob_id_in};
    // Incoming operands are captured from the CDBs in the same cycle so no wakeup is lost.
    assign w_new     = wake(w_in_raw, w_cdb_alu, w_cdb_lsb);
    assign w_win     = w_woken[w_sel_idx];

    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            w_woken[i] = wake(r_ent[i], w_cdb_alu, w_cdb_lsb);
            w_free[i]  = !r_ent[i].valid;
`ifdef RS_WAKEUP_BYPASS_EN
            w_ready[i] = r_ent[i].valid && (w_woken[i].qi == TAG_READY)
                         && (w_woken[i].qj == TAG_READY);
`else
            w_ready[i] = r_ent[i].valid && (r_ent[i].qi == TAG_READY)
                         && (r_ent[i].qj == TAG_READY);
`endif
        end
    end

    rs_select #(.N(RS_SIZE), .W(IDX_W)) u_sel (
        .i_req     (w_ready),
        .o_idx_c   (w_sel_idx),
        .o_found_c (w_sel_found)
    );

    rs_select #(.N(RS_SIZE), .W(IDX_W)) u_free (
        .i_req     (w_free),
        .o_idx_c   (w_free_idx),
        .o_found_c (w_free_found)
    );

    always_comb begin
        w_ins       = 1'b0;
        w_disp      = 1'b0;
        w_count_nxt = r_count;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            w_ent_nxt[i] = w_woken[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                w_ent_nxt[i].valid = 1'b0;
            end
            w_count_nxt = '0;
        end else begin
            w_disp = w_sel_found;
            w_ins  = ena_rs && w_free_found;
            // Free slot comes from the pre-cycle state, so it never collides with the winner.
            if (w_disp) begin
                w_ent_nxt[w_sel_idx].valid = 1'b0;
            end
            if (w_ins) begin
                w_ent_nxt[w_free_idx] = w_new;
            end
            w_count_nxt = r_count + CNT_W'(w_ins) - CNT_W'(w_disp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                r_ent[i] <= '0;
            end
            r_count    <= '0;
            rs_full    <= 1'b0;
            alu_ena    <= 1'b0;
            alu_op     <= '0;
            alu_vi     <= '0;
            alu_vj     <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_rob_id <= '0;
        end else if (rdy) begin
            r_ent   <= w_ent_nxt;
            r_count <= w_count_nxt;
            // One more instruction may already be in the registered issue stage.
            rs_full <= (CNT_W'(RS_SIZE) - w_count_nxt) <= CNT_W'(1);
            alu_ena <= w_disp;
            if (w_disp) begin
                alu_op     <= w_win.op;
                alu_vi     <= w_win.vi;
                alu_vj     <= w_win.vj;
                alu_imm    <= w_win.imm;
                alu_pc     <= w_win.pc;
                alu_rob_id <= w_win.rob_id;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (rdy && !flush && ena_rs) |-> (r_count != CNT_W'(RS_SIZE)));

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed vector table, hand sequences and a random run vs. a reference model.
module tb_rs_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, flush, ena_rs;
    logic [5:0]  op_in;
    logic [3:0]  Qi_in, Qj_in, rob_id_in, cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] Vi_in, Vj_in, imm_in, pc_in, cdb_alu_val, cdb_lsb_val;
    logic        cdb_alu_ok, cdb_lsb_ok;
    logic        rs_full, alu_ena;
    logic [5:0]  alu_op;
    logic [31:0] alu_vi, alu_vj, alu_imm, alu_pc;
    logic [3:0]  alu_rob_id;

    int checks   = 0;
    int failures = 0;

    rs_scheduler dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .ena_rs(ena_rs),
        .op_in(op_in), .Qi_in(Qi_in), .Qj_in(Qj_in), .Vi_in(Vi_in), .Vj_in(Vj_in),
        .imm_in(imm_in), .pc_in(pc_in), .rob_id_in(rob_id_in), .rs_full(rs_full),
        .cdb_alu_ok(cdb_alu_ok), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_ok(cdb_lsb_ok), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
        .alu_ena(alu_ena), .alu_op(alu_op), .alu_vi(alu_vi), .alu_vj(alu_vj),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
    );

    // Reference model: a plain array of slots plus the expected registered outputs.
    bit          m_v   [16];
    logic [3:0]  m_qi  [16];
    logic [3:0]  m_qj  [16];
    logic [3:0]  m_rob [16];
    logic [5:0]  m_op  [16];
    logic [31:0] m_vi  [16];
    logic [31:0] m_vj  [16];
    logic [31:0] m_imm [16];
    logic [31:0] m_pc  [16];
    bit          e_ena, e_full;
    logic [5:0]  e_op;
    logic [31:0] e_vi, e_vj, e_imm, e_pc;
    logic [3:0]  e_rob;

    function automatic bit hit(input logic [3:0] q);
        return (q != 4'd0) && ((cdb_alu_ok && q == cdb_alu_tag) || (cdb_lsb_ok && q == cdb_lsb_tag));
    endfunction

    function automatic logic [31:0] res_val(input logic [3:0] q, input logic [31:0] v);
        if (q != 4'd0 && cdb_alu_ok && q == cdb_alu_tag) return cdb_alu_val;
        if (q != 4'd0 && cdb_lsb_ok && q == cdb_lsb_tag) return cdb_lsb_val;
        return v;
    endfunction

    function automatic logic [3:0] res_tag(input logic [3:0] q);
        return hit(q) ? 4'd0 : q;
    endfunction

    function automatic bit src_ok(input logic [3:0] q);
`ifdef RS_WAKEUP_BYPASS_EN
        return (q == 4'd0) || hit(q);
`else
        return q == 4'd0;
`endif
    endfunction

    task automatic model_step();
        int fr, sel, n;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            e_ena = 0; e_full = 0; e_op = 0; e_vi = 0; e_vj = 0; e_imm = 0; e_pc = 0; e_rob = 0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            e_ena = 0; e_full = 0;
            return;
        end
        fr = -1; sel = -1;
        for (int i = 0; i < 16; i++) begin
            if (fr < 0 && !m_v[i]) fr = i;
            if (sel < 0 && m_v[i] && src_ok(m_qi[i]) && src_ok(m_qj[i])) sel = i;
        end
        for (int i = 0; i < 16; i++) begin
            if (m_v[i]) begin
                m_vi[i] = res_val(m_qi[i], m_vi[i]); m_qi[i] = res_tag(m_qi[i]);
                m_vj[i] = res_val(m_qj[i], m_vj[i]); m_qj[i] = res_tag(m_qj[i]);
            end
        end
        e_ena = (sel >= 0);
        if (sel >= 0) begin
            e_op = m_op[sel]; e_vi = m_vi[sel]; e_vj = m_vj[sel];
            e_imm = m_imm[sel]; e_pc = m_pc[sel]; e_rob = m_rob[sel];
            m_v[sel] = 1'b0;
        end
        if (ena_rs && fr >= 0) begin
            m_v[fr] = 1'b1; m_op[fr] = op_in; m_imm[fr] = imm_in; m_pc[fr] = pc_in;
            m_rob[fr] = rob_id_in;
            m_vi[fr] = res_val(Qi_in, Vi_in); m_qi[fr] = res_tag(Qi_in);
            m_vj[fr] = res_val(Qj_in, Vj_in); m_qj[fr] = res_tag(Qj_in);
        end
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_v[i]);
        e_full = (16 - n) <= 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("mdl_ena",  32'(alu_ena),    32'(e_ena));
        chk("mdl_full", 32'(rs_full),    32'(e_full));
        chk("mdl_op",   32'(alu_op),     32'(e_op));
        chk("mdl_vi",   alu_vi,          e_vi);
        chk("mdl_vj",   alu_vj,          e_vj);
        chk("mdl_imm",  alu_imm,         e_imm);
        chk("mdl_pc",   alu_pc,          e_pc);
        chk("mdl_rob",  32'(alu_rob_id), 32'(e_rob));
    endtask

    task automatic set_idle();
        rdy = 1; flush = 0; ena_rs = 0; op_in = 0; Qi_in = 0; Qj_in = 0; Vi_in = 0; Vj_in = 0;
        imm_in = 0; pc_in = 0; rob_id_in = 0;
        cdb_alu_ok = 0; cdb_alu_tag = 0; cdb_alu_val = 0;
        cdb_lsb_ok = 0; cdb_lsb_tag = 0; cdb_lsb_val = 0;
    endtask

    task automatic ins(input logic [3:0] qi, input logic [3:0] qj, input logic [31:0] vi,
                       input logic [31:0] vj, input logic [3:0] rob);
        ena_rs = 1; Qi_in = qi; Qj_in = qj; Vi_in = vi; Vj_in = vj; rob_id_in = rob;
        op_in = 6'(rob) + 6'd1; imm_in = vi ^ 32'hA5; pc_in = {26'h0, rob, 2'b00} + 32'h1000;
    endtask

    task automatic chk_out(input string tag, input bit ena, input logic [31:0] vi,
                           input logic [31:0] vj, input logic [3:0] rob);
        chk({tag, "_ena"}, 32'(alu_ena), 32'(ena));
        chk({tag, "_vi"},  alu_vi, vi);
        chk({tag, "_vj"},  alu_vj, vj);
        chk({tag, "_rob"}, 32'(alu_rob_id), 32'(rob));
    endtask

    typedef struct {
        bit ena; logic [3:0] qi, qj; logic [31:0] vi, vj; logic [3:0] rob;
        bit aok; logic [3:0] atag; logic [31:0] aval;
        bit lok; logic [3:0] ltag; logic [31:0] lval;
        bit x_ena; logic [31:0] x_vi, x_vj; logic [3:0] x_rob;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit ena, logic [3:0] qi, logic [3:0] qj, logic [31:0] vi,
                                logic [31:0] vj, logic [3:0] rob, bit aok, logic [3:0] atag,
                                logic [31:0] aval, bit lok, logic [3:0] ltag, logic [31:0] lval,
                                bit x_ena, logic [31:0] x_vi, logic [31:0] x_vj, logic [3:0] x_rob);
        vec_t v;
        v.ena = ena; v.qi = qi; v.qj = qj; v.vi = vi; v.vj = vj; v.rob = rob;
        v.aok = aok; v.atag = atag; v.aval = aval; v.lok = lok; v.ltag = ltag; v.lval = lval;
        v.x_ena = x_ena; v.x_vi = x_vi; v.x_vj = x_vj; v.x_rob = x_rob;
        return v;
    endfunction

    initial begin
        //              ena qi qj vi      vj  rob aok tag val       lok tag val      x_ena vi      vj     rob
        tbl.push_back(mk(1, 0, 0, 5,      7,  3,  0,  0,  0,        0,  0,  0,       0,    0,      0,     0));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       1,    5,      7,     3));
        tbl.push_back(mk(1, 0, 6, 1,      0,  5,  0,  0,  0,        1,  6,  9,       0,    5,      7,     3));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       1,    1,      9,     5));
        tbl.push_back(mk(1, 4, 0, 'hAA,   2,  7,  0,  0,  0,        0,  0,  0,       0,    1,      9,     5));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  1,  0,  'hDEAD,   0,  0,  0,       0,    1,      9,     5));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       0,    1,      9,     5));
`ifdef RS_WAKEUP_BYPASS_EN
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  1,  4,  'h10,     0,  0,  0,       1,    'h10,   2,     7));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       0,    'h10,   2,     7));
        tbl.push_back(mk(1, 8, 9, 0,      0,  2,  0,  0,  0,        0,  0,  0,       0,    'h10,   2,     7));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  1,  8,  'h111,    1,  9,  'h222,   1,    'h111,  'h222, 2));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       0,    'h111,  'h222, 2));
`else
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  1,  4,  'h10,     0,  0,  0,       0,    1,      9,     5));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       1,    'h10,   2,     7));
        tbl.push_back(mk(1, 8, 9, 0,      0,  2,  0,  0,  0,        0,  0,  0,       0,    'h10,   2,     7));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  1,  8,  'h111,    1,  9,  'h222,   0,    'h10,   2,     7));
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       1,    'h111,  'h222, 2));
`endif
        tbl.push_back(mk(0, 0, 0, 0,      0,  0,  0,  0,  0,        0,  0,  0,       0,    'h111,  'h222, 2));

        // Reset state
        set_idle(); rst = 1;
        repeat (3) step();
        chk_out("rst", 0, 0, 0, 0);
        chk("rst_full", 32'(rs_full), 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_pc", alu_pc, 0);
        rst = 0;

        // Directed vector table
        foreach (tbl[k]) begin
            set_idle();
            if (tbl[k].ena) ins(tbl[k].qi, tbl[k].qj, tbl[k].vi, tbl[k].vj, tbl[k].rob);
            cdb_alu_ok = tbl[k].aok; cdb_alu_tag = tbl[k].atag; cdb_alu_val = tbl[k].aval;
            cdb_lsb_ok = tbl[k].lok; cdb_lsb_tag = tbl[k].ltag; cdb_lsb_val = tbl[k].lval;
            step();
            chk_out($sformatf("vec%0d", k), tbl[k].x_ena, tbl[k].x_vi, tbl[k].x_vj, tbl[k].x_rob);
            chk($sformatf("vec%0d_full", k), 32'(rs_full), 0);
        end

        // Fill 15 blocked entries, each waiting on a distinct tag
        for (int k = 0; k < 15; k++) begin
            set_idle();
            ins(4'(k + 1), 4'd0, 32'(k), 32'(k), 4'(k));
            step();
            chk($sformatf("fill%0d_full", k), 32'(rs_full), 32'(k == 14));
            chk($sformatf("fill%0d_ena", k), 32'(alu_ena), 0);
        end
        set_idle(); cdb_alu_ok = 1; cdb_alu_tag = 4'd1; cdb_alu_val = 32'h55;
        step();
`ifdef RS_WAKEUP_BYPASS_EN
        chk_out("wake", 1, 32'h55, 0, 0);
        chk("wake_full", 32'(rs_full), 0);
        set_idle(); step();
        chk("wake2_ena", 32'(alu_ena), 0);
`else
        chk("wake_ena", 32'(alu_ena), 0);
        chk("wake_full", 32'(rs_full), 1);
        set_idle(); step();
        chk_out("wake2", 1, 32'h55, 0, 0);
        chk("wake2_full", 32'(rs_full), 0);
`endif

        // Flush with a simultaneous insert: everything, including the insert, is dropped
        set_idle(); flush = 1; ins(4'd0, 4'd0, 32'hBEEF, 32'd1, 4'd11);
        step();
        chk("flush_ena", 32'(alu_ena), 0);
        chk("flush_full", 32'(rs_full), 0);
        set_idle(); step();
        chk("flush_ins_ena", 32'(alu_ena), 0);
        set_idle(); cdb_alu_ok = 1; cdb_alu_tag = 4'd2; cdb_lsb_ok = 1; cdb_lsb_tag = 4'd3;
        step();
        chk("flush_wake_ena", 32'(alu_ena), 0);
        set_idle(); step();
        chk("flush_wake2_ena", 32'(alu_ena), 0);

        // rdy=0 freezes state and holds outputs
        set_idle(); ins(4'd0, 4'd0, 32'h77, 32'h78, 4'd9); step();
        chk("hold_pre_ena", 32'(alu_ena), 0);
        set_idle(); step();
        chk_out("hold_disp", 1, 32'h77, 32'h78, 9);
        for (int k = 0; k < 2; k++) begin
            set_idle(); rdy = 0; ins(4'd0, 4'd0, 32'hBAD, 32'd0, 4'd1);
            cdb_alu_ok = 1; cdb_alu_tag = 4'd9; cdb_alu_val = 32'h1;
            step();
            chk_out($sformatf("hold%0d", k), 1, 32'h77, 32'h78, 9);
        end
        set_idle(); ins(4'd5, 4'd0, 32'd0, 32'd3, 4'd12); step();
        chk("frz_ins_ena", 32'(alu_ena), 0);
        for (int k = 0; k < 2; k++) begin
            set_idle(); rdy = 0; cdb_alu_ok = 1; cdb_alu_tag = 4'd5; cdb_alu_val = 32'h99;
            step();
            chk($sformatf("frz%0d_ena", k), 32'(alu_ena), 0);
        end
        set_idle(); step();
        chk("frz_after_ena", 32'(alu_ena), 0);
        set_idle(); cdb_alu_ok = 1; cdb_alu_tag = 4'd5; cdb_alu_val = 32'h99; step();
`ifdef RS_WAKEUP_BYPASS_EN
        chk_out("frz_wake", 1, 32'h99, 32'd3, 12);
`else
        chk("frz_wake_ena", 32'(alu_ena), 0);
        set_idle(); step();
        chk_out("frz_wake", 1, 32'h99, 32'd3, 12);
`endif
        set_idle(); step();

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if (!e_full && $urandom_range(0, 2) != 0) begin
                ins($urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom_range(1, 15)),
                    $urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom_range(1, 15)),
                    $urandom, $urandom, 4'($urandom_range(0, 15)));
                op_in  = 6'($urandom);
                imm_in = $urandom;
                pc_in  = $urandom;
            end
            cdb_alu_ok = ($urandom_range(0, 1) != 0); cdb_alu_tag = 4'($urandom_range(0, 15));
            cdb_alu_val = $urandom;
            cdb_lsb_ok = ($urandom_range(0, 1) != 0); cdb_lsb_tag = 4'($urandom_range(0, 15));
            cdb_lsb_val = $urandom;
            if (cdb_alu_ok && cdb_lsb_ok && cdb_alu_tag == cdb_lsb_tag) cdb_lsb_ok = 0;
            step();
        end

        // Reset again from a busy state
        set_idle(); rst = 1;
        repeat (3) step();
        chk_out("rst2", 0, 0, 0, 0);
        chk("rst2_full", 32'(rs_full), 0);
        chk("rst2_imm", alu_imm, 0);
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
